// File: rtl/rx_gearbox_collector_pkg.sv
// rtl/rx_gearbox_collector_pkg.sv - shared widths and state type for the RX gearbox collector
package rx_collector_pkg;

    localparam int IN_WIDTH   = 47;
    localparam int OUT_WIDTH  = 66;
    localparam int CNT_WIDTH  = 16;
    localparam int ACC_WIDTH  = OUT_WIDTH + IN_WIDTH - 1;
    localparam int FILL_WIDTH = 7;

    // Bit counts sized to the fill register so comparisons stay width-matched
    localparam logic [FILL_WIDTH-1:0] OUT_BITS = FILL_WIDTH'(OUT_WIDTH);
    localparam logic [FILL_WIDTH-1:0] IN_BITS  = FILL_WIDTH'(IN_WIDTH);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rx_gearbox_collector_if.sv
// rtl/rx_gearbox_collector_if.sv - upstream pop handshake, block output and status bundle
interface rx_gearbox_collector_if;

    logic                                      canpop_collector;
    logic                                      issync_collector;
    logic                                      pop_collector;
    logic [rx_collector_pkg::IN_WIDTH-1:0]     data_collector;
    logic                                      data_valid_collector;
    logic [rx_collector_pkg::OUT_WIDTH-1:0]    out_block;
    logic                                      out_valid;
    logic                                      out_ready;
    logic                                      aligned;
    logic [rx_collector_pkg::CNT_WIDTH-1:0]    sync_cnt;
    logic [rx_collector_pkg::CNT_WIDTH-1:0]    slip_cnt;

    // Collector side
    modport master (
        input  canpop_collector,
        input  issync_collector,
        input  data_collector,
        input  data_valid_collector,
        input  out_ready,
        output pop_collector,
        output out_block,
        output out_valid,
        output aligned,
        output sync_cnt,
        output slip_cnt
    );

    // FIFO / downstream side
    modport slave (
        output canpop_collector,
        output issync_collector,
        output data_collector,
        output data_valid_collector,
        output out_ready,
        input  pop_collector,
        input  out_block,
        input  out_valid,
        input  aligned,
        input  sync_cnt,
        input  slip_cnt
    );

endinterface

// File: rtl/rx_gearbox_collector_acc.sv
// rtl/rx_gearbox_collector_acc.sv - accumulator/fill shift-insert datapath of the gearbox
module rx_gearbox_acc
    import rx_collector_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  emit,
    input  logic                  capture,
    input  logic                  clear,
    input  logic [IN_WIDTH-1:0]   data,
    output logic [FILL_WIDTH-1:0] fill,
    output logic [FILL_WIDTH-1:0] fill_a,
    output logic [OUT_WIDTH-1:0]  head
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_a;
    logic [ACC_WIDTH-1:0] ins;

    // Bits above fill are always zero, so an OR places the new word without masking
    always_comb begin
        acc_a  = acc;
        fill_a = fill;
        if (emit) begin
            acc_a  = acc >> OUT_WIDTH;
            fill_a = fill - OUT_BITS;
        end
        ins = ACC_WIDTH'(data) << fill_a;
    end

    assign head = acc[OUT_WIDTH-1:0];

    // Update accumulator: a consumed sync drops the residue left after this cycle's emit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= '0;
            fill <= '0;
        end else if (enable) begin
            if (clear) begin
                acc  <= '0;
                fill <= '0;
            end else if (capture) begin
                acc  <= acc_a | ins;
                fill <= fill_a + IN_BITS;
            end else begin
                acc  <= acc_a;
                fill <= fill_a;
            end
        end
    end

endmodule

// File: rtl/rx_gearbox_collector.sv
// rtl/rx_gearbox_collector.sv - pops 47-bit words and repacks them into 66-bit PCS blocks
module rx_gearbox_collector
    import rx_collector_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_enable,
    rx_gearbox_collector_if.master bus
);

    state_t                 state;
    logic [FILL_WIDTH-1:0]  fill;
    logic [FILL_WIDTH-1:0]  fill_a;
    logic [OUT_WIDTH-1:0]   head;
    logic [OUT_WIDTH-1:0]   block_q;
    logic                   valid_q;
    logic                   aligned_q;
    logic [CNT_WIDTH-1:0]   sync_q;
    logic [CNT_WIDTH-1:0]   slip_q;
    logic                   emit;
    logic                   take;
    logic                   take_sync;
    logic                   capture;

    // Emit when a whole block is buffered and the output slot is free or being drained
    assign emit = in_enable && (fill >= OUT_BITS) && (!valid_q || bus.out_ready);

    // Sync words always pop; data words only while there is room for a full word
    assign bus.pop_collector = in_enable && bus.canpop_collector &&
                               (state == HUNT || bus.issync_collector || fill_a < OUT_BITS);

    assign take      = in_enable && bus.data_valid_collector;
    assign take_sync = take && bus.issync_collector;
    assign capture   = take && !bus.issync_collector && (state == RUN);

    rx_gearbox_acc u_acc (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (in_enable),
        .emit    (emit),
        .capture (capture),
        .clear   (take_sync),
        .data    (bus.data_collector),
        .fill    (fill),
        .fill_a  (fill_a),
        .head    (head)
    );

    // Alignment FSM, output block register and saturating status counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HUNT;
            block_q   <= '0;
            valid_q   <= 1'b0;
            aligned_q <= 1'b0;
            sync_q    <= '0;
            slip_q    <= '0;
        end else if (in_enable) begin
            if (emit) begin
                block_q <= head;
                valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
            if (take_sync) begin
                state     <= RUN;
                aligned_q <= 1'b1;
                if (sync_q != '1) begin
                    sync_q <= sync_q + 1'b1;
                end
                if (state == RUN && fill_a != '0 && slip_q != '1) begin
                    slip_q <= slip_q + 1'b1;
                end
            end
        end
    end

    assign bus.out_block = block_q;
    assign bus.out_valid = valid_q;
    assign bus.aligned   = aligned_q;
    assign bus.sync_cnt  = sync_q;
    assign bus.slip_cnt  = slip_q;

endmodule

// File: tb/tb_rx_gearbox_collector.sv
// tb/tb_rx_gearbox_collector.sv - self-checking bench for the RX gearbox collector
module tb_rx_gearbox_collector;
    import rx_collector_pkg::*;

    localparam logic [47:0] SYNC = 48'h8000_0000_0000;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic in_enable = 1'b1;

    rx_gearbox_collector_if bus();

    rx_gearbox_collector dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_enable (in_enable),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    // Upstream FIFO qualifies a pop with its own valid
    assign bus.data_valid_collector = bus.canpop_collector & bus.pop_collector;

    int checks = 0;
    int errors = 0;

    logic [47:0] src_q[$];
    bit          mq[$];
    logic [65:0] exp_q[$];
    logic [65:0] got_q[$];
    logic [65:0] t2_blocks[$];
    int          pops;
    bit          m_run;
    logic [15:0] m_sync;
    logic [15:0] m_slip;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [47:0] dw(input int i);
        logic [63:0] v;
        v = 64'h0000_1357_9BDF_0246 + 64'(i) * 64'h0000_0F1E_2D3C_4B5A;
        return {1'b0, v[46:0]};
    endfunction

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Model: a plain bit stream; every 66 buffered bits form a block, a sync discards what is left
    task automatic model_consume(input logic [47:0] w);
        logic [65:0] blk;
        if (w[47]) begin
            if (m_run && mq.size() != 0) m_slip = sat(m_slip);
            mq.delete();
            m_sync = sat(m_sync);
            m_run = 1'b1;
        end else if (m_run) begin
            for (int b = 0; b < 47; b++) mq.push_back(w[b]);
            while (mq.size() >= 66) begin
                for (int b = 0; b < 66; b++) blk[b] = mq.pop_front();
                exp_q.push_back(blk);
            end
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        src_q.delete();
        got_q.delete();
        pops = 0;
        m_run = 1'b0;
        m_sync = '0;
        m_slip = '0;
    endtask

    // Present upstream head, then compare outputs and record this cycle's consumption
    initial begin
        logic [47:0] w;
        logic [65:0] e;
        bus.canpop_collector = 1'b0;
        bus.issync_collector = 1'b0;
        bus.data_collector   = '0;
        forever begin
            @(negedge clock);
            #1;
            if (src_q.size() != 0) begin
                w = src_q[0];
                bus.canpop_collector = 1'b1;
                bus.issync_collector = w[47];
                bus.data_collector   = w[46:0];
            end else begin
                bus.canpop_collector = 1'b0;
                bus.issync_collector = 1'b0;
                bus.data_collector   = '0;
            end
            #1;
            if (reset_n) begin
                chk("aligned", 66'(bus.aligned), 66'(m_run));
                chk("sync_cnt", 66'(bus.sync_cnt), 66'(m_sync));
                chk("slip_cnt", 66'(bus.slip_cnt), 66'(m_slip));
                if (!in_enable) chk("pop_disabled", 66'(bus.pop_collector), 66'd0);
                if (in_enable && bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_block", bus.out_block, 66'hx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("block", bus.out_block, e);
                    end
                    got_q.push_back(bus.out_block);
                end
                if (in_enable && bus.data_valid_collector) begin
                    w = src_q.pop_front();
                    pops++;
                    model_consume(w);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset(input string name);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        model_clear();
        #1;
        chk({name, "_rst_valid"}, 66'(bus.out_valid), 66'd0);
        chk({name, "_rst_aligned"}, 66'(bus.aligned), 66'd0);
        chk({name, "_rst_sync"}, 66'(bus.sync_cnt), 66'd0);
        chk({name, "_rst_slip"}, 66'(bus.slip_cnt), 66'd0);
        chk({name, "_rst_block"}, bus.out_block, 66'd0);
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < 2000) begin
            cyc(1);
            n++;
        end
        cyc(3);
        chk({name, "_drained"}, 66'(src_q.size() + exp_q.size()), 66'd0);
    endtask

    task automatic push_stream(input int nwords);
        src_q.push_back(SYNC);
        for (int i = 0; i < nwords; i++) src_q.push_back(dw(i));
    endtask

    initial begin
        logic [47:0] w0, w1, w2;
        int k;
        bus.out_ready = 1'b1;

        // T1: data words before sync are popped and discarded
        do_reset("t1");
        for (int i = 0; i < 5; i++) src_q.push_back(dw(i));
        src_q.push_back(SYNC);
        drain("t1");
        chk("t1_pops", 66'(pops), 66'd6);
        chk("t1_blocks", 66'(got_q.size()), 66'd0);
        chk("t1_valid", 66'(bus.out_valid), 66'd0);
        chk("t1_aligned", 66'(bus.aligned), 66'd1);
        chk("t1_sync", 66'(bus.sync_cnt), 66'd1);

        // T2: 66 words = 3102 bits = exactly 47 blocks
        do_reset("t2");
        push_stream(66);
        drain("t2");
        chk("t2_blocks", 66'(got_q.size()), 66'd47);
        chk("t2_residue", 66'(mq.size()), 66'd0);
        chk("t2_slip", 66'(bus.slip_cnt), 66'd0);
        w0 = dw(0);
        w1 = dw(1);
        if (got_q.size() != 0) chk("t2_first_block", got_q[0], {w1[18:0], w0[46:0]});
        t2_blocks = got_q;

        // T3: 141 bits then sync -> 2 blocks, 9-bit residue dropped
        do_reset("t3");
        w0 = 48'h0123_4567_89AB;
        w1 = 48'h7EDC_BA98_7654;
        w2 = 48'h5555_AAAA_3333;
        src_q.push_back(SYNC);
        src_q.push_back(w0);
        src_q.push_back(w1);
        src_q.push_back(w2);
        src_q.push_back(SYNC);
        drain("t3");
        chk("t3_blocks", 66'(got_q.size()), 66'd2);
        if (got_q.size() == 2) begin
            chk("t3_block0", got_q[0], {w1[18:0], w0[46:0]});
            chk("t3_block1", got_q[1], {w2[37:0], w1[46:19]});
        end
        chk("t3_slip", 66'(bus.slip_cnt), 66'd1);
        chk("t3_sync", 66'(bus.sync_cnt), 66'd2);

        // T4: backpressure holds one block and stops data pops at fill >= 66
        do_reset("t4");
        bus.out_ready = 1'b0;
        push_stream(5);
        cyc(20);
        chk("t4_pops", 66'(pops), 66'd4);
        chk("t4_left", 66'(src_q.size()), 66'd2);
        chk("t4_held_valid", 66'(bus.out_valid), 66'd1);
        w0 = dw(0);
        w1 = dw(1);
        chk("t4_held_block", bus.out_block, {w1[18:0], w0[46:0]});
        bus.out_ready = 1'b1;
        drain("t4");
        chk("t4_blocks", 66'(got_q.size()), 66'd3);

        // T5: enabled one cycle in three gives the same block sequence as T2
        do_reset("t5");
        push_stream(66);
        k = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && k < 3000) begin
            in_enable = (k % 3 == 0);
            cyc(1);
            k++;
        end
        in_enable = 1'b1;
        drain("t5");
        chk("t5_blocks", 66'(got_q.size()), 66'(t2_blocks.size()));
        for (int i = 0; i < got_q.size() && i < t2_blocks.size(); i++)
            chk("t5_vs_t2", got_q[i], t2_blocks[i]);

        // T6: asynchronous reset in the middle of a stream
        do_reset("t6a");
        push_stream(66);
        cyc(40);
        chk("t6_mid_aligned", 66'(bus.aligned), 66'd1);
        chk("t6_mid_progress", 66'(got_q.size() > 0), 66'd1);
        do_reset("t6");
        cyc(5);
        chk("t6_after_valid", 66'(bus.out_valid), 66'd0);
        chk("t6_after_aligned", 66'(bus.aligned), 66'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
